e203_exu_wbck_arb: RTL

Write-back arbiter directly downstream of the regular ALU in the E203 execute stage. It buffers regular-ALU write-back results in a 2-entry FIFO and arbitrates them against the long-pipe write-back source (LSU/MULDIV) onto the single integer register-file write port. Long-pipe results have priority, and a starvation counter bounds the wait of a buffered ALU result.

---
 rtl/e203_exu_wbck_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter: buffers ALU results in a 2-deep FIFO and merges them with long-pipe results onto the RF write port.
// Latency: long-pipe 0 cycles (combinational), ALU >= 1 cycle (registered through the FIFO).
// Backpressure: ALU ready = !full | pop; long-pipe ready only when granted; starvation counter force-grants the ALU head.

module e203_wbck_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign head_dat = mem[rptr];

endmodule

module e203_exu_wbck_arb #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               alu_wbck_i_rdwen,
  input  logic               alu_wbck_i_err,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  output logic               rf_wbck_o_ena,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic [1:0]         alu_fifo_cnt,
  output logic               wbck_busy
);

  typedef struct packed {
    logic [XLEN-1:0]    wdat;
    logic [RFIDX_W-1:0] rdidx;
  } alu_ent_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  alu_ent_t   push_ent;
  alu_ent_t   head_ent;
  logic [1:0] cnt;
  logic [2:0] starve_cnt;
  logic       head_v;
  logic       full;
  logic       force_alu;
  logic       grant_alu;
  logic       grant_longp;
  logic       is_write;
  logic       push;

  assign head_v    = (cnt != 2'd0);
  assign full      = (cnt == 2'd2);
  assign force_alu = head_v && (starve_cnt == STARVE_LIM);

  // Nothing is granted while rst is high, so no write leaks out of a reset cycle.
  assign grant_longp = !rst && !force_alu && longp_wbck_i_valid;
  assign grant_alu   = !rst && head_v && (force_alu || !longp_wbck_i_valid);

  assign is_write = alu_wbck_i_rdwen && !alu_wbck_i_err && (alu_wbck_i_rdidx != '0);
  assign alu_wbck_i_ready = !rst && (!full || grant_alu);
  assign push = alu_wbck_i_valid && alu_wbck_i_ready && is_write;

  assign push_ent.wdat  = alu_wbck_i_wdat;
  assign push_ent.rdidx = alu_wbck_i_rdidx;

  e203_wbck_fifo2 #(
    .W ($bits(alu_ent_t))
  ) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (grant_alu),
    .head_dat (head_ent),
    .cnt      (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (grant_alu || !head_v) begin
      starve_cnt <= 3'd0;
    end else if (grant_longp && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign longp_wbck_i_ready = grant_longp;
  assign rf_wbck_o_ena      = grant_longp || grant_alu;

  always_comb begin
    rf_wbck_o_wdat  = '0;
    rf_wbck_o_rdidx = '0;
    if (grant_longp) begin
      rf_wbck_o_wdat  = longp_wbck_i_wdat;
      rf_wbck_o_rdidx = longp_wbck_i_rdidx;
    end else if (grant_alu) begin
      rf_wbck_o_wdat  = head_ent.wdat;
      rf_wbck_o_rdidx = head_ent.rdidx;
    end
  end

  assign alu_fifo_cnt = rst ? 2'd0 : cnt;
  assign wbck_busy    = !rst && (head_v || longp_wbck_i_valid);

endmodule
